// File: rtl/wb_uart_tx.sv
// ============================================================================
//  Module   : wb_uart_tx
//  Brief    : Wishbone slave with a byte FIFO feeding an 8N1 UART transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_uart_tx #(
  parameter int CLK_DIV    = 217,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        tx_out
);

  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_BAUD_W = $clog2(CLK_DIV);

  localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0]  c_FULL     = c_CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic                r_ack;
  logic                r_err;
  logic [31:0]         r_rdata;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wptr;
  logic [c_PTR_W-1:0]  r_rptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;

  logic        w_req;
  logic        w_full;
  logic        w_empty;
  logic        w_data_wr;
  logic        w_push;
  logic        w_ovf;
  logic        w_pop;
  logic        w_tick;
  logic        w_busy;
  logic        w_tx;
  logic [3:0]  w_cnt_field;
  logic [31:0] w_status;
  logic        w_unused;

  // A response in flight blocks a new request, so a held strobe is not serviced twice.
  assign w_req     = wb_cyc & wb_stb & ~(r_ack | r_err);
  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  assign w_data_wr = w_req & wb_we & ~wb_addr[2];
  assign w_push    = w_data_wr & wb_sel[0] & ~w_full;
  assign w_ovf     = w_data_wr & wb_sel[0] & w_full;
  assign w_pop     = (r_state == c_IDLE) & ~w_empty;
  assign w_tick    = (r_baud == '0);

  assign w_cnt_field = 4'(r_count);
  assign w_status    = {20'd0, w_cnt_field, 5'd0, w_busy, w_empty, w_full};
  assign w_unused    = ^{wb_sel[3:1], wb_addr[31:3], wb_addr[1:0], wb_wdata[31:8]};

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_req & ~w_ovf;
      r_err   <= w_ovf;
      r_rdata <= (w_req & ~wb_we & wb_addr[2]) ? w_status : 32'd0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wptr] <= wb_wdata[7:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (!w_empty) w_state_nxt = c_START;
      c_START: if (w_tick) w_state_nxt = c_DATA;
      c_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_state_nxt = c_STOP;
      c_STOP:  if (w_tick) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_tx   = 1'b1;
    w_busy = 1'b1;
    case (r_state)
      c_IDLE:  w_busy = 1'b0;
      c_START: w_tx   = 1'b0;
      c_DATA:  w_tx   = r_shift[0];
      default: w_tx   = 1'b1;
    endcase
  end

  // Counter reloads on every bit boundary while a frame is active and rests at 0 in IDLE.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if ((w_state_nxt != c_IDLE) && ((w_state_nxt != r_state) || w_tick)) begin
        r_baud <= c_BAUD_MAX;
      end else if (!w_tick) begin
        r_baud <= r_baud - c_BAUD_W'(1);
      end

      if (w_pop) begin
        r_shift <= r_mem[r_rptr];
      end else if ((r_state == c_DATA) && w_tick) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end

      if (r_state == c_START) begin
        r_bit_idx <= '0;
      end else if ((r_state == c_DATA) && w_tick) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  assign wb_ack   = r_ack;
  assign wb_err   = r_err;
  assign wb_rdata = r_rdata;
  assign tx_out   = w_tx;

endmodule

`default_nettype wire

// File: tb/tb_wb_uart_tx.sv
// ============================================================================
//  Module   : tb_wb_uart_tx
//  Brief    : Self-checking bench for wb_uart_tx with a queue-based UART line model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_uart_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME      = 10 * CLK_DIV;

  localparam logic [31:0] c_DATA_ADDR = 32'h3000_0000;
  localparam logic [31:0] c_STAT_ADDR = 32'h3000_0004;

  logic        clk_in   = 1'b0;
  logic        reset_in = 1'b1;
  logic        wb_cyc   = 1'b0;
  logic        wb_stb   = 1'b0;
  logic        wb_we    = 1'b0;
  logic [3:0]  wb_sel   = 4'd0;
  logic [31:0] wb_addr  = 32'd0;
  logic [31:0] wb_wdata = 32'd0;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic        wb_err;
  logic        tx_out;

  wb_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_sel   (wb_sel),
    .wb_addr  (wb_addr),
    .wb_wdata (wb_wdata),
    .wb_rdata (wb_rdata),
    .wb_ack   (wb_ack),
    .wb_err   (wb_err),
    .tx_out   (tx_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Line model: every frame is {start 0, 8 data bits LSB first, stop 1}, CLK_DIV cycles per bit.
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         mon_en   = 1'b0;
  bit         in_frame = 1'b0;
  logic [7:0] cur_byte = 8'd0;
  logic       prev_tx  = 1'b1;
  int         fstart   = 0;
  int         ncyc     = 0;

  always @(negedge clk_in) begin
    int   pos;
    logic eb;
    ncyc++;
    if (!mon_en) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && prev_tx && !tx_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          cur_byte = exp_q.pop_front();
          in_frame = 1'b1;
          fstart   = ncyc;
          start_q.push_back(ncyc);
        end
      end
      if (in_frame) begin
        pos = ncyc - fstart;
        if (pos < CLK_DIV)          eb = 1'b0;
        else if (pos < 9 * CLK_DIV) eb = cur_byte[(pos / CLK_DIV) - 1];
        else                        eb = 1'b1;
        check("tx_line_bit", {31'd0, tx_out}, {31'd0, eb});
        if (pos == FRAME - 1) in_frame = 1'b0;
      end
    end
    prev_tx = tx_out;
  end

  task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdata, output logic ack, output logic err,
                         output logic [31:0] rdata);
    @(posedge clk_in); #1;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_sel   = sel;
    wb_addr  = addr;
    wb_wdata = wdata;
    @(posedge clk_in); #1;
    ack    = wb_ack;
    err    = wb_err;
    rdata  = wb_rdata;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    for (int k = 0; k < 5000 && (exp_q.size() != 0 || in_frame); k++) @(posedge clk_in);
    done = (exp_q.size() == 0) && !in_frame;
    check("drain_done", {31'd0, done}, 32'd1);
    repeat (2) @(posedge clk_in);
  endtask

  typedef struct {
    logic        a2;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        eack;
    logic        eerr;
    logic [31:0] erd;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [7];
    logic        ack;
    logic        err;
    logic [31:0] rd;
    logic [31:0] d;
    logic [31:0] ra;
    logic [9:0]  pat;
    logic [7:0]  b0;
    int          nops;
    int          kind;

    vt[0] = '{1'b1, 1'b0, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0002};
    vt[1] = '{1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
    vt[2] = '{1'b0, 1'b0, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0};
    vt[3] = '{1'b0, 1'b1, 4'hE, 32'hFFFF_FF3C, 1'b1, 1'b0, 32'h0};
    vt[4] = '{1'b1, 1'b0, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0002};
    vt[5] = '{1'b1, 1'b1, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0};
    vt[6] = '{1'b1, 1'b0, 4'h1, 32'h0,         1'b1, 1'b0, 32'h0000_0002};

    repeat (3) @(posedge clk_in);
    #1;
    check("reset_tx", {31'd0, tx_out}, 32'd1);
    check("reset_ack", {31'd0, wb_ack}, 32'd0);
    check("reset_err", {31'd0, wb_err}, 32'd0);
    check("reset_rdata", wb_rdata, 32'd0);
    reset_in = 1'b0;
    mon_en   = 1'b1;

    for (int i = 0; i < 7; i++) begin
      wb_xfer(vt[i].a2 ? c_STAT_ADDR : c_DATA_ADDR, vt[i].we, vt[i].sel, vt[i].wdata, ack, err, rd);
      check("vec_ack", {31'd0, ack}, {31'd0, vt[i].eack});
      check("vec_err", {31'd0, err}, {31'd0, vt[i].eerr});
      if (!vt[i].we) check("vec_rdata", rd, vt[i].erd);
    end
    repeat (20) @(posedge clk_in);
    #1;
    check("idle_tx", {31'd0, tx_out}, 32'd1);

    // Single byte: push, pop next cycle, start bit the cycle after.
    exp_q.push_back(8'hA5);
    wb_xfer(c_DATA_ADDR, 1'b1, 4'hF, 32'h0000_00A5, ack, err, rd);
    check("a5_ack", {31'd0, ack}, 32'd1);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk_in); #1;
      check("a5_pattern", {31'd0, tx_out}, {31'd0, pat[i / CLK_DIV]});
    end
    @(posedge clk_in); #1;
    check("a5_after_stop", {31'd0, tx_out}, 32'd1);
    wait_drain();

    // Overflow: first byte starts at once, the next eight fill the FIFO, the tenth is refused.
    start_q.delete();
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      if (i < 9) exp_q.push_back(d[7:0]);
      wb_xfer(c_DATA_ADDR, 1'b1, 4'hF, d, ack, err, rd);
      check("ovf_ack", {31'd0, ack}, (i < 9) ? 32'd1 : 32'd0);
      check("ovf_err", {31'd0, err}, (i < 9) ? 32'd0 : 32'd1);
    end
    wb_xfer(c_STAT_ADDR, 1'b0, 4'hF, 32'h0, ack, err, rd);
    check("ovf_status", rd, 32'h0000_0805);
    wait_drain();
    check("ovf_frames", start_q.size(), 32'd9);
    for (int k = 1; k < start_q.size(); k++) begin
      check("ovf_spacing", start_q[k] - start_q[k-1], FRAME + 1);
    end

    // Strobe held five cycles: responses on alternate cycles, one push per ack.
    d = $urandom;
    repeat (3) exp_q.push_back(d[7:0]);
    @(posedge clk_in); #1;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = 1'b1;
    wb_sel   = 4'hF;
    wb_addr  = c_DATA_ADDR;
    wb_wdata = d;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk_in); #1;
      check("hold_ack", {31'd0, wb_ack}, (j % 2 == 0) ? 32'd1 : 32'd0);
      check("hold_err", {31'd0, wb_err}, 32'd0);
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    wait_drain();

    // Reset during data bit 3 of the first frame with three bytes still queued.
    b0 = 8'($urandom);
    exp_q.push_back(b0);
    wb_xfer(c_DATA_ADDR, 1'b1, 4'hF, {24'd0, b0}, ack, err, rd);
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      wb_xfer(c_DATA_ADDR, 1'b1, 4'hF, d, ack, err, rd);
    end
    repeat (12) @(posedge clk_in);
    #1;
    check("pre_reset_bit3", {31'd0, tx_out}, {31'd0, b0[3]});
    mon_en   = 1'b0;
    reset_in = 1'b1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    check("post_reset_tx", {31'd0, tx_out}, 32'd1);
    exp_q.delete();
    wb_xfer(c_STAT_ADDR, 1'b0, 4'hF, 32'h0, ack, err, rd);
    check("post_reset_status", rd, 32'h0000_0002);
    mon_en = 1'b1;
    repeat (100) @(posedge clk_in);
    #1;
    check("post_reset_quiet", {31'd0, tx_out}, 32'd1);

    // Random bursts of mixed accesses, each burst drained before the next.
    for (int it = 0; it < 15; it++) begin
      nops = $urandom_range(1, 4);
      for (int n = 0; n < nops; n++) begin
        kind = $urandom_range(0, 3);
        d    = $urandom;
        ra   = $urandom;
        ra[2] = (kind == 2);
        if (kind <= 1) begin
          wb_sel = 4'($urandom);
          if (wb_sel[0]) exp_q.push_back(d[7:0]);
          wb_xfer(ra, 1'b1, wb_sel, d, ack, err, rd);
        end else if (kind == 2) begin
          wb_xfer(ra, 1'b1, 4'($urandom), d, ack, err, rd);
        end else begin
          wb_xfer(ra, 1'b0, 4'hF, 32'h0, ack, err, rd);
          check("rnd_data_read", rd, 32'd0);
        end
        check("rnd_ack", {31'd0, ack}, 32'd1);
        check("rnd_err", {31'd0, err}, 32'd0);
        repeat ($urandom_range(0, 3)) @(posedge clk_in);
      end
      wait_drain();
      wb_xfer(c_STAT_ADDR, 1'b0, 4'hF, 32'h0, ack, err, rd);
      check("rnd_status_idle", rd, 32'h0000_0002);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
